mcpu_ctrl: RTL and testbench

MCPU_CTRL -- requirements
Module: mcpu_ctrl

---
 rtl/mcpu_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback strobes for the datapath.
// Define MCPU_SLTI_EN to add slti support through the EXI/WBI states.
module mcpu_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OPcode,
   input  logic [5:0] Fun,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       CPU_MIO,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALU_Control,
   output logic [3:0] state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCPU_SLTI_EN
   localparam logic [5:0] OP_SLTI  = 6'b001010;
`endif

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IF  = 4'd0,
      S_ID  = 4'd1,
      S_MA  = 4'd2,
      S_MRD = 4'd3,
      S_WBL = 4'd4,
      S_MWR = 4'd5,
      S_EXR = 4'd6,
      S_WBR = 4'd7,
      S_BEQ = 4'd8,
      S_JMP = 4'd9,
      S_EXI = 4'd10,
      S_WBI = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic       reg_write;
      logic       reg_dst;
      logic       cpu_mio;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_ctrl;
   } ctrl_t;

   state_t     cur_state;
   state_t     next_state;
   logic       is_load;
   logic       fun_ok;
   logic [2:0] fun_alu;
   ctrl_t      ctrl;
   ctrl_t      ctrl_out;

   // The ALU equal flag is consumed by the datapath's branch gating, not here.
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      fun_ok  = 1'b1;
      fun_alu = ALU_ADD;
      case (Fun)
         6'b100000: fun_alu = ALU_ADD;
         6'b100010: fun_alu = ALU_SUB;
         6'b100100: fun_alu = ALU_AND;
         6'b100101: fun_alu = ALU_OR;
         6'b101010: fun_alu = ALU_SLT;
         6'b100111: fun_alu = ALU_NOR;
         default:   fun_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_IF;
      end else begin
         cur_state <= next_state;
      end
   end

   // Remember lw vs sw at decode so MA never looks at a stale opcode.
   always_ff @(posedge clk) begin
      if (rst) begin
         is_load <= 1'b0;
      end else if (cur_state == S_ID) begin
         is_load <= (OPcode == OP_LW);
      end
   end

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         S_IF: begin
            if (MIO_ready) next_state = S_ID;
         end
         S_ID: begin
            case (OPcode)
               OP_RTYPE:     next_state = fun_ok ? S_EXR : S_IF;
               OP_LW, OP_SW: next_state = S_MA;
               OP_BEQ:       next_state = S_BEQ;
               OP_J:         next_state = S_JMP;
`ifdef MCPU_SLTI_EN
               OP_SLTI:      next_state = S_EXI;
`endif
               default:      next_state = S_IF;
            endcase
         end
         S_MA:  next_state = is_load ? S_MRD : S_MWR;
         S_MRD: next_state = MIO_ready ? S_WBL : S_MRD;
         S_WBL: next_state = S_IF;
         S_MWR: next_state = MIO_ready ? S_IF : S_MWR;
         S_EXR: next_state = S_WBR;
         S_WBR: next_state = S_IF;
         S_BEQ: next_state = S_IF;
         S_JMP: next_state = S_IF;
`ifdef MCPU_SLTI_EN
         S_EXI: next_state = S_WBI;
         S_WBI: next_state = S_IF;
`endif
         default: next_state = S_IF;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (cur_state)
         S_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.cpu_mio   = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_ctrl  = ALU_ADD;
            ctrl.pc_source = PC_ALU;
            ctrl.ir_write  = MIO_ready;
            ctrl.pc_write  = MIO_ready;
         end
         S_ID: begin
            ctrl.alu_src_b = SRCB_BROFF;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         S_MA: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_ctrl  = ALU_ADD;
         end
         S_MRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.cpu_mio  = 1'b1;
         end
         S_WBL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.cpu_mio   = 1'b1;
         end
         S_EXR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_ctrl  = fun_alu;
         end
         S_WBR: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_ctrl      = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PC_ALUOUT;
         end
         S_JMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_JUMP;
         end
`ifdef MCPU_SLTI_EN
         S_EXI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_ctrl  = ALU_SLT;
         end
         S_WBI: begin
            ctrl.reg_write = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

   // Reset masks every output combinationally, so the reset cycle itself is quiet.
   assign ctrl_out = rst ? '0 : ctrl;

   assign PCWrite     = ctrl_out.pc_write;
   assign PCWriteCond = ctrl_out.pc_write_cond;
   assign IorD        = ctrl_out.iord;
   assign MemRead     = ctrl_out.mem_read;
   assign MemWrite    = ctrl_out.mem_write;
   assign IRWrite     = ctrl_out.ir_write;
   assign MemtoReg    = ctrl_out.mem_to_reg;
   assign ALUSrcA     = ctrl_out.alu_src_a;
   assign RegWrite    = ctrl_out.reg_write;
   assign RegDst      = ctrl_out.reg_dst;
   assign CPU_MIO     = ctrl_out.cpu_mio;
   assign ALUSrcB     = ctrl_out.alu_src_b;
   assign PCSource    = ctrl_out.pc_source;
   assign ALU_Control = ctrl_out.alu_ctrl;
   assign state       = rst ? 4'd0 : cur_state;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: instruction-path model checked every cycle plus literal spot checks.
module tb_mcpu_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] OPcode;
   logic [5:0] Fun;
   logic       zero;
   logic       MIO_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, ALUSrcA, RegWrite, RegDst, CPU_MIO;
   logic [1:0] ALUSrcB;
   logic [1:0] PCSource;
   logic [2:0] ALU_Control;
   logic [3:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   mcpu_ctrl dut (
      .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .CPU_MIO(CPU_MIO), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .ALU_Control(ALU_Control), .state(state)
   );

   always #5 clk = ~clk;

   logic [17:0] dut_outs;
   assign dut_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                      ALUSrcA, RegWrite, RegDst, CPU_MIO, ALUSrcB, PCSource, ALU_Control};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, want, $time);
   endtask

   function automatic logic [2:0] alu_of_fun(input logic [5:0] fn);
      case (fn)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         6'b100111: return 3'b100;
         default:   return 3'b010;
      endcase
   endfunction

   // Output table per state code, in the dut_outs field order.
   function automatic logic [17:0] spec_outs(input int s, input logic rdy, input logic [5:0] fn);
      logic pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, mio;
      logic [1:0] bsel, psrc;
      logic [2:0] alu;
      {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, mio} = '0;
      bsel = 2'b00; psrc = 2'b00; alu = 3'b000;
      case (s)
         0:  begin mr = 1; mio = 1; bsel = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
         1:  begin bsel = 2'b11; alu = 3'b010; end
         2:  begin asa = 1; bsel = 2'b10; alu = 3'b010; end
         3:  begin mr = 1; iord = 1; mio = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iord = 1; mio = 1; end
         6:  begin asa = 1; alu = alu_of_fun(fn); end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; alu = 3'b110; pcwc = 1; psrc = 2'b01; end
         9:  begin pcw = 1; psrc = 2'b10; end
         10: begin asa = 1; bsel = 2'b10; alu = 3'b111; end
         11: begin rw = 1; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd, mio, bsel, psrc, alu};
   endfunction

   // Instruction-level model: after decode, the remaining path is a fixed list of states.
   int exp_state = 0;
   int path[$];
   bit model_valid = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_state = 0;
         path.delete();
         model_valid = 1'b1;
      end else if (model_valid) begin
         if (exp_state == 0) begin
            if (MIO_ready) exp_state = 1;
         end else if ((exp_state == 3 || exp_state == 5) && !MIO_ready) begin
            exp_state = exp_state;
         end else begin
            if (exp_state == 1) begin
               path.delete();
               if (OPcode == 6'h00) begin
                  if (Fun inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111}) begin
                     path.push_back(6); path.push_back(7);
                  end
               end else if (OPcode == 6'b100011) begin
                  path.push_back(2); path.push_back(3); path.push_back(4);
               end else if (OPcode == 6'b101011) begin
                  path.push_back(2); path.push_back(5);
               end else if (OPcode == 6'b000100) begin
                  path.push_back(8);
               end else if (OPcode == 6'b000010) begin
                  path.push_back(9);
               end
`ifdef MCPU_SLTI_EN
               else if (OPcode == 6'b001010) begin
                  path.push_back(10); path.push_back(11);
               end
`endif
            end
            if (path.size() > 0) exp_state = path.pop_front();
            else exp_state = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         chk("outs", {14'd0, dut_outs}, rst ? 32'd0 : {14'd0, spec_outs(exp_state, MIO_ready, Fun)});
         chk("state", {28'd0, state}, rst ? 32'd0 : exp_state);
      end
   end

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   task automatic see(input string nm, input int s);
      @(negedge clk);
      chk(nm, {28'd0, state}, s);
   endtask

   logic [5:0] fun_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
   logic [2:0] alu_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b100};

   initial begin
      rst = 1'b1; OPcode = 6'h00; Fun = 6'h00; zero = 1'b0; MIO_ready = 1'b1;
      see("rst_state", 0);
      chk("rst_outs", {14'd0, dut_outs}, 0);
      go();
      rst = 1'b0; OPcode = 6'h00; Fun = 6'b100010;
      see("r_if", 0);
      chk("r_if_memread", MemRead, 1); chk("r_if_mio", CPU_MIO, 1); chk("r_if_irw", IRWrite, 1);
      go(); see("r_id", 1);
      go(); see("r_exr", 6); chk("r_exr_alu", ALU_Control, 3'b110);
      go(); see("r_wbr", 7); chk("r_wbr_rw", RegWrite, 1); chk("r_wbr_rd", RegDst, 1);
      go(); OPcode = 6'b100011; see("lw_if", 0);
      go(); see("lw_id", 1);
      go(); see("lw_ma", 2);
      go(); MIO_ready = 1'b0; see("lw_mrd0", 3); chk("lw_mrd_rw", RegWrite, 0);
      go(); see("lw_mrd1", 3);
      go(); see("lw_mrd2", 3);
      go(); MIO_ready = 1'b1; see("lw_mrd3", 3); chk("lw_mrd3_rw", RegWrite, 0);
      go(); see("lw_wbl", 4);
      chk("lw_wbl_rw", RegWrite, 1); chk("lw_wbl_m2r", MemtoReg, 1); chk("lw_wbl_rd", RegDst, 0);
      go(); OPcode = 6'b101011; MIO_ready = 1'b0; see("if_stall", 0); chk("if_stall_irw", IRWrite, 0);
      go(); MIO_ready = 1'b1; see("sw_if", 0);
      go(); see("sw_id", 1);
      go(); OPcode = 6'h3f; see("sw_ma", 2);
      go(); MIO_ready = 1'b0; see("sw_mwr", 5); chk("sw_mwr_mw", MemWrite, 1);
      go(); rst = 1'b1; see("sw_rst", 0);
      chk("sw_rst_mw", MemWrite, 0); chk("sw_rst_outs", {14'd0, dut_outs}, 0);
      go(); rst = 1'b0; MIO_ready = 1'b1; OPcode = 6'b000100; zero = 1'b1;
      see("rst_if", 0); chk("rst_if_memread", MemRead, 1);
      go(); see("beq_id", 1);
      go(); see("beq", 8);
      chk("beq_pcwc", PCWriteCond, 1); chk("beq_psrc", PCSource, 2'b01); chk("beq_alu", ALU_Control, 3'b110);
      go(); OPcode = 6'b000010; zero = 1'b0; see("beq_if", 0);
      go(); see("j_id", 1);
      go(); see("j", 9); chk("j_pcw", PCWrite, 1); chk("j_psrc", PCSource, 2'b10);
      go(); OPcode = 6'h3f; see("j_if", 0);
      go(); see("ill_id", 1);
      chk("ill_strobes", {27'd0, RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite}, 0);
      go(); OPcode = 6'h00; Fun = 6'h00; see("ill_if", 0);
      go(); see("badfun_id", 1);
      chk("badfun_strobes", {27'd0, RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite}, 0);
      go(); OPcode = 6'b001010; see("badfun_if", 0);
      go(); see("slti_id", 1);
      chk("slti_id_strobes", {27'd0, RegWrite, MemWrite, PCWrite, PCWriteCond, IRWrite}, 0);
      go();
`ifdef MCPU_SLTI_EN
      see("slti_exi", 10); chk("slti_alu", ALU_Control, 3'b111);
      go(); see("slti_wbi", 11); chk("slti_rw", RegWrite, 1); chk("slti_rd", RegDst, 0);
      go(); see("slti_if", 0);
`else
      see("slti_if", 0);
`endif
      for (int i = 0; i < 6; i++) begin
         go(); OPcode = 6'h00; Fun = fun_tab[i]; see("rs_id", 1);
         go(); see("rs_exr", 6); chk("rs_alu", ALU_Control, alu_tab[i]);
         go(); see("rs_wbr", 7);
         go(); see("rs_if", 0);
      end
      go();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
